// File: rtl/constants_pkg.sv
// Shared Argon v1.5 bus constants: word and command widths, unit IDs,
// error codes and the stack-unit opcodes.
package constants_pkg;

  localparam int WORDSIZE      = 16;
  localparam int COMMAND_WIDTH = 4;

  typedef logic [WORDSIZE-1:0] word_t;
  typedef logic [3:0]          error_t;

  localparam logic [3:0] ID_STACK = 4'h4;

  localparam error_t ERROR_NONE               = 4'h0;
  localparam error_t ERROR_STACK_OVERFLOW     = 4'h1;
  localparam error_t ERROR_STACK_UNDERFLOW    = 4'h2;
  localparam error_t ERROR_INVALID_INPUT_DATA = 4'hF;

  localparam logic [COMMAND_WIDTH-1:0] CMD_NOP   = 4'h0;
  localparam logic [COMMAND_WIDTH-1:0] CMD_PUSH  = 4'h1;
  localparam logic [COMMAND_WIDTH-1:0] CMD_POP   = 4'h2;
  localparam logic [COMMAND_WIDTH-1:0] CMD_PEEK  = 4'h3;
  localparam logic [COMMAND_WIDTH-1:0] CMD_CLEAR = 4'h4;
  localparam logic [COMMAND_WIDTH-1:0] CMD_COUNT = 4'h5;
  localparam logic [COMMAND_WIDTH-1:0] CMD_WMARK = 4'h6;

endpackage

// File: rtl/stack_unit_if.sv
// Command/response bus between the Argon bus master and the stack unit.
interface stack_unit_if;
  import constants_pkg::*;

  logic                     i_valid;
  logic [3:0]               i_unit_id;
  logic [COMMAND_WIDTH-1:0] i_command;
  word_t                    i_data;
  logic                     o_ready;
  logic                     o_valid;
  word_t                    o_data;
  error_t                   o_error;
  logic                     o_empty;
  logic                     o_full;

  modport master (
    output i_valid, i_unit_id, i_command, i_data,
    input  o_ready, o_valid, o_data, o_error, o_empty, o_full
  );

  modport slave (
    input  i_valid, i_unit_id, i_command, i_data,
    output o_ready, o_valid, o_data, o_error, o_empty, o_full
  );

endinterface

// File: rtl/stack_mem.sv
// Stack storage: DEPTH x WORDSIZE, one synchronous write port and one
// synchronous read port. Contents are never reset.
module stack_mem
  import constants_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  word_t         wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output word_t         rdata_o
);

  word_t mem_q [DEPTH];
  word_t rdata_q;

  // Write port
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Registered read port
  always_ff @(posedge clk) begin
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/stack_unit.sv
// Hardware LIFO bus unit. Accepts one command per transaction, runs it in
// EXEC, presents a one-cycle response in RESP.
// Optional feature macro: STACK_WATERMARK_EN (high-water register + CMD_WMARK).
module stack_unit
  import constants_pkg::*;
#(
  parameter int         DEPTH   = 16,
  parameter logic [3:0] UNIT_ID = ID_STACK
) (
  input logic         clk,
  input logic         rst_n,
  stack_unit_if.slave bus
);

  localparam int              SP_W    = $clog2(DEPTH + 1);
  localparam int              AW      = $clog2(DEPTH);
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t                   state_q;
  logic                     ready_q, valid_q, empty_q, full_q;
  word_t                    odata_q;
  error_t                   oerr_q;
  logic [SP_W-1:0]          sp_q, sp_d;
  logic [COMMAND_WIDTH-1:0] cmd_q;
  word_t                    arg_q;
  word_t                    res_data_q, ex_data_d;
  error_t                   res_err_q, ex_err_d;
  logic                     res_rd_q, ex_rd_d;
  logic                     mem_we, mem_re, accept;
  word_t                    mem_rdata;

`ifdef STACK_WATERMARK_EN
  logic [SP_W-1:0] wmark_q;

  // High-water mark follows the peak stack occupancy; CLEAR leaves it alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              wmark_q <= '0;
    else if (sp_q > wmark_q) wmark_q <= sp_q;
  end
`endif

  assign accept = (state_q == S_IDLE) && ready_q && bus.i_valid &&
                  (bus.i_unit_id == UNIT_ID);

  // Execute-stage decode: next pointer, memory strobes and response fields
  always_comb begin
    sp_d      = sp_q;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    ex_data_d = '0;
    ex_err_d  = ERROR_NONE;
    ex_rd_d   = 1'b0;
    if (state_q == S_EXEC) begin
      case (cmd_q)
        CMD_NOP: ;
        CMD_PUSH: begin
          if (sp_q == SP_FULL) begin
            ex_err_d  = ERROR_STACK_OVERFLOW;
            ex_data_d = WORDSIZE'(DEPTH);
          end else begin
            mem_we    = 1'b1;
            sp_d      = sp_q + SP_W'(1);
            ex_data_d = WORDSIZE'(sp_d);
          end
        end
        CMD_POP, CMD_PEEK: begin
          if (sp_q == '0) begin
            ex_err_d = ERROR_STACK_UNDERFLOW;
          end else begin
            mem_re  = 1'b1;
            ex_rd_d = 1'b1;
            if (cmd_q == CMD_POP) sp_d = sp_q - SP_W'(1);
          end
        end
        CMD_CLEAR: sp_d = '0;
        CMD_COUNT: ex_data_d = WORDSIZE'(sp_q);
`ifdef STACK_WATERMARK_EN
        CMD_WMARK: ex_data_d = WORDSIZE'(wmark_q);
`endif
        default:   ex_err_d = ERROR_INVALID_INPUT_DATA;
      endcase
    end
  end

  // Control FSM with registered bus outputs; RESP spends one cycle waiting
  // for the synchronous read, then one cycle with o_valid high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ready_q    <= 1'b1;
      valid_q    <= 1'b0;
      odata_q    <= '0;
      oerr_q     <= ERROR_NONE;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      sp_q       <= '0;
      cmd_q      <= CMD_NOP;
      arg_q      <= '0;
      res_data_q <= '0;
      res_err_q  <= ERROR_NONE;
      res_rd_q   <= 1'b0;
    end else begin
      sp_q    <= sp_d;
      empty_q <= (sp_q == '0);
      full_q  <= (sp_q == SP_FULL);
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            cmd_q   <= bus.i_command;
            arg_q   <= bus.i_data;
            ready_q <= 1'b0;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          res_data_q <= ex_data_d;
          res_err_q  <= ex_err_d;
          res_rd_q   <= ex_rd_d;
          state_q    <= S_RESP;
        end
        S_RESP: begin
          if (!valid_q) begin
            valid_q <= 1'b1;
            odata_q <= res_rd_q ? mem_rdata : res_data_q;
            oerr_q  <= res_err_q;
          end else begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  stack_mem #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (AW'(sp_q)),
    .wdata_i (arg_q),
    .re_i    (mem_re),
    .raddr_i (AW'(sp_q - SP_W'(1))),
    .rdata_o (mem_rdata)
  );

  assign bus.o_ready = ready_q;
  assign bus.o_valid = valid_q;
  assign bus.o_data  = odata_q;
  assign bus.o_error = oerr_q;
  assign bus.o_empty = empty_q;
  assign bus.o_full  = full_q;

endmodule

// File: doc/stack_unit.md
# stack_unit

Hardware LIFO bus unit for Argon v1.5, answering bus unit ID `ID_STACK`. Sits on the internal command bus next to the ALU, register file and debug units. It accepts one command per transaction from the bus master, executes it against an on-chip word stack, and returns one response word plus an error code.

## Interface
Parameters:
- `DEPTH`, 16: number of stack entries; power of two, at least 2.
- `UNIT_ID`, `ID_STACK` (4'h4): bus ID this unit responds to.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `i_valid`  in  1  bus command strobe.
- `i_unit_id`  in  4  target unit ID of the command.
- `i_command`  in  `COMMAND_WIDTH` (4)  opcode.
- `i_data`  in  `WORDSIZE` (16)  operand (`word_t`).
- `o_ready`  out  1  unit can accept a command.
- `o_valid`  out  1  response strobe, one cycle wide.
- `o_data`  out  16  response word.
- `o_error`  out  4  error code (`error_t`); 0 means no error.
- `o_empty`  out  1  stack holds 0 entries.
- `o_full`  out  1  stack holds `DEPTH` entries.

## Operation
- **Accept**: a command is accepted when `i_valid && o_ready && i_unit_id == UNIT_ID`. A command carrying any other ID is ignored. The master holds the command until it sees `o_ready`.
- **Pointer**: `sp` counts entries, range 0..`DEPTH`, width `$clog2(DEPTH+1)`. `sp` is the write address for a push; `sp-1` is the top of stack.
- **FSM**:
  - IDLE (`o_ready`=1) -> EXEC on accept. The opcode and operand are latched.
  - EXEC -> RESP unconditionally. The memory write or read is performed here.
  - RESP (`o_valid`=1) -> IDLE.
- **Commands**:
  - `CMD_NOP` 4'h0: no state change; `o_data`=0.
  - `CMD_PUSH` 4'h1: write `i_data` at `sp`, then `sp`+1. `o_data`=new count.
  - `CMD_POP` 4'h2: `o_data`=top, then `sp`-1.
  - `CMD_PEEK` 4'h3: `o_data`=top; `sp` unchanged.
  - `CMD_CLEAR` 4'h4: `sp`=0; `o_data`=0.
  - `CMD_COUNT` 4'h5: `o_data`=`sp`, zero-extended.
  - Any other opcode: `o_error`=`ERROR_INVALID_INPUT_DATA` (4'hF), `o_data`=0, no state change.
- **Boundaries**:
  - PUSH when full: `o_error`=`ERROR_STACK_OVERFLOW` (4'h1). No write; `sp` holds; `o_data`=`DEPTH`.
  - POP or PEEK when empty: `o_error`=`ERROR_STACK_UNDERFLOW` (4'h2); `o_data`=0; `sp` holds.
  - `sp` never wraps.
- **Flags**: `o_empty` and `o_full` are decoded from the registered `sp` and update the cycle after `sp` changes.

## Timing
- **Latency**: a command accepted at edge N gives `o_valid` high for the cycle after edge N+2. `o_ready` returns high after edge N+3.
- **Throughput**: one command per 3 cycles.
- **Response hold**: `o_data` and `o_error` are valid only while `o_valid`=1. They are held at their last values otherwise.
- **Reset values**: `o_ready`=1, `o_valid`=0, `o_data`=0, `o_error`=0, `o_empty`=1, `o_full`=0, `sp`=0, FSM=IDLE.
- **Reset mid-operation**: reset in EXEC or RESP aborts the command with no response; the stack is emptied. Memory contents are not reset; they are unreachable because `sp`=0.
- **Ignored inputs**: `i_valid` while `o_ready`=0 is ignored.

## Configuration
- `STACK_WATERMARK_EN`
  - **Defined**: adds a high-water register `wmark`, reset to 0. Whenever `sp` exceeds `wmark`, `wmark` is updated to `sp`. `CMD_WMARK` 4'h6 returns `wmark`, zero-extended. `CMD_CLEAR` does not reset `wmark`.
  - **Undefined**: no register exists, and 4'h6 is an invalid opcode (4'hF).

## Structure
- **Package `constants_pkg`** gains:
  - `error_t` (logic [3:0]);
  - `ERROR_NONE` = 4'h0, `ERROR_STACK_OVERFLOW` = 4'h1, `ERROR_STACK_UNDERFLOW` = 4'h2;
  - the `CMD_*` stack opcodes as `COMMAND_WIDTH` constants.
  
  `ERROR_INVALID_INPUT_DATA` is fixed at 4'hF.
- **FSM state enum** stays local to the module.
- **Sub-module `stack_mem`**: `DEPTH` x `WORDSIZE`, synchronous write and synchronous read, one port each. It is instantiated once.

## Test plan
- **Push then pop**: after reset, PUSH 16'hABCD then POP -> PUSH responds `o_data`=1, err 0; POP responds 16'hABCD, err 0, `o_empty`=1.
- **Fill and overflow**: PUSH 16 distinct words, then PUSH 16'h1234 -> the 16th push gives `o_full`=1; the 17th gives err 4'h1, `o_data`=16, and COUNT returns 16. Sixteen POPs then return the words in reverse order.
- **Underflow**: POP and PEEK on an empty stack -> err 4'h2, `o_data`=0, COUNT=0.
- **Other unit / invalid opcode**: command with `i_unit_id`=4'h1 -> no `o_valid`, `o_ready` stays 1. Opcode 4'h9 -> err 4'hF, `o_data`=0.
- **Timing and reset**: check accept-to-`o_valid` is 2 edges and that `o_ready` is low for 3 cycles. PUSH, then assert `rst_n`=0 during EXEC -> no response, COUNT=0 afterwards.
- **Watermark** (with `STACK_WATERMARK_EN`): PUSH x5, POP x3, CLEAR, `CMD_WMARK` -> `o_data`=5. Without the macro, `CMD_WMARK` returns err 4'hF.
